// File: rtl/add_unit.sv
// ---------------------------------------------------------------------------
// add_unit
//    Two-operand WIDTH-bit adder for the datapath (PC+4, branch targets).
//    The sum wraps modulo 2^WIDTH. The adder also produces carry, signed-overflow
//    and zero flags. A one-cycle registered copy of the result and flags is
//    provided for pipelined consumers.
//
// Ports
//    clk      in   1      rising-edge clock for the registered copy
//    rst_n    in   1      synchronous, active-low reset (registered path only)
//    a        in   WIDTH  operand A (unsigned or two's complement)
//    b        in   WIDTH  operand B
//    out      out  WIDTH  combinational a+b, modulo 2^WIDTH
//    cout     out  1      combinational carry out of the MSB (unsigned overflow)
//    ovf      out  1      combinational two's-complement overflow
//    zero     out  1      combinational out == 0
//    out_q    out  WIDTH  registered out
//    cout_q   out  1      registered cout
//    ovf_q    out  1      registered ovf
//    zero_q   out  1      registered zero
//    valid_q  out  1      set once a result has been captured since reset
// ---------------------------------------------------------------------------
module add_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] out,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic [WIDTH-1:0] out_q,
   output logic             cout_q,
   output logic             ovf_q,
   output logic             zero_q,
   output logic             valid_q
);

   // Signed overflow: the operands agree in sign but the result does not.
   function automatic logic f_signed_ovf(input logic a_msb,
                                         input logic b_msb,
                                         input logic s_msb);
      f_signed_ovf = (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

   function automatic logic f_is_zero(input logic [WIDTH-1:0] v);
      f_is_zero = ~|v;
   endfunction

   // Operands viewed as two's complement; the overflow flag uses their signs.
   logic signed [WIDTH-1:0] w_a_s;
   logic signed [WIDTH-1:0] w_b_s;
   logic        [WIDTH:0]   w_sum_ext;
   logic        [WIDTH-1:0] w_sum;
   logic                    w_cout;
   logic                    w_ovf;
   logic                    w_zero;

   logic        [WIDTH-1:0] r_out_p1;
   logic                    r_cout_p1;
   logic                    r_ovf_p1;
   logic                    r_zero_p1;
   logic                    r_vld_p1;

   // ---- stage p0: combinational sum and flags ----
   assign w_a_s     = $signed(a);
   assign w_b_s     = $signed(b);
   assign w_sum_ext = {1'b0, a} + {1'b0, b};
   assign w_sum     = w_sum_ext[WIDTH-1:0];
   assign w_cout    = w_sum_ext[WIDTH];
   assign w_ovf     = f_signed_ovf(w_a_s[WIDTH-1], w_b_s[WIDTH-1], w_sum[WIDTH-1]);
   assign w_zero    = f_is_zero(w_sum);

   assign out  = w_sum;
   assign cout = w_cout;
   assign ovf  = w_ovf;
   assign zero = w_zero;

   // ---- stage p1: registered copy ----
   // The reset image of zero_q is 1 so that it stays consistent with out_q == 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_p1  <= '0;
         r_cout_p1 <= 1'b0;
         r_ovf_p1  <= 1'b0;
         r_zero_p1 <= 1'b1;
         r_vld_p1  <= 1'b0;
      end else begin
         r_out_p1  <= w_sum;
         r_cout_p1 <= w_cout;
         r_ovf_p1  <= w_ovf;
         r_zero_p1 <= w_zero;
         r_vld_p1  <= 1'b1;
      end
   end

   assign out_q   = r_out_p1;
   assign cout_q  = r_cout_p1;
   assign ovf_q   = r_ovf_p1;
   assign zero_q  = r_zero_p1;
   assign valid_q = r_vld_p1;

endmodule

// File: tb/tb_add_unit.sv
module tb_add_unit;

   localparam int WIDTH = 32;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] out;
   logic             cout;
   logic             ovf;
   logic             zero;
   logic [WIDTH-1:0] out_q;
   logic             cout_q;
   logic             ovf_q;
   logic             zero_q;
   logic             valid_q;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [WIDTH-1:0] o;
      logic             c;
      logic             v;
      logic             z;
      logic             vld;
   } exp_t;

   exp_t sb[$];

   add_unit #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .a       (a),
      .b       (b),
      .out     (out),
      .cout    (cout),
      .ovf     (ovf),
      .zero    (zero),
      .out_q   (out_q),
      .cout_q  (cout_q),
      .ovf_q   (ovf_q),
      .zero_q  (zero_q),
      .valid_q (valid_q)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: carry from unsigned wrap-around, overflow from the
   // mathematically exact signed sum falling outside the representable range.
   function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  input logic rst_active_low);
      exp_t   e;
      longint s;
      if (!rst_active_low) begin
         e = '{o: '0, c: 1'b0, v: 1'b0, z: 1'b1, vld: 1'b0};
      end else begin
         e.o   = x + y;
         e.c   = (e.o < x);
         s     = longint'($signed(x)) + longint'($signed(y));
         e.v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         e.z   = (e.o == '0);
         e.vld = 1'b1;
      end
      return e;
   endfunction

   task automatic check_comb(input string tag, input logic [WIDTH-1:0] eo,
                             input logic ec, input logic ev, input logic ez);
      check({tag, ".out"},  64'(out),  64'(eo));
      check({tag, ".cout"}, 64'(cout), 64'(ec));
      check({tag, ".ovf"},  64'(ovf),  64'(ev));
      check({tag, ".zero"}, 64'(zero), 64'(ez));
   endtask

   // Push the expectation for the coming edge, take the edge, compare.
   task automatic tick(input string tag);
      exp_t e;
      sb.push_back(model(a, b, rst_n));
      @(posedge clk);
      #1;
      checks++;
      assert (sb.size() != 0) else begin
         failures++;
         $error("FAIL %s.sb observed=empty expected=entry", tag);
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check({tag, ".out_q"},   64'(out_q),   64'(e.o));
         check({tag, ".cout_q"},  64'(cout_q),  64'(e.c));
         check({tag, ".ovf_q"},   64'(ovf_q),   64'(e.v));
         check({tag, ".zero_q"},  64'(zero_q),  64'(e.z));
         check({tag, ".valid_q"}, 64'(valid_q), 64'(e.vld));
      end
   endtask

   task automatic apply(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic [WIDTH-1:0] eo, input logic ec, input logic ev, input logic ez);
      a = x;
      b = y;
      #1;
      check_comb(tag, eo, ec, ev, ez);
      tick(tag);
   endtask

   initial begin
      exp_t e;
      logic [WIDTH-1:0] ra, rb;

      rst_n = 1'b0;
      a     = 32'd5;
      b     = 32'd10;
      #10;
      check_comb("t1_5p10", 32'd15, 1'b0, 1'b0, 1'b0);

      // Reset held for two edges while operands are present: reset wins.
      tick("rst_hold0");
      tick("rst_hold1");
      check("rst_out_q_lit",   64'(out_q),   64'd0);
      check("rst_zero_q_lit",  64'(zero_q),  64'd1);
      check("rst_valid_q_lit", 64'(valid_q), 64'd0);

      rst_n = 1'b1;
      tick("rel_5p10");
      check("rel_out_q_lit",   64'(out_q),   64'd15);
      check("rel_valid_q_lit", 64'(valid_q), 64'd1);

      apply("t2_1000",   32'd1000,      32'd2000,      32'd3000,      1'b0, 1'b0, 1'b0);
      apply("t2_123456", 32'd123456,    32'd789,       32'd124245,    1'b0, 1'b0, 1'b0);
      apply("t3_zero",   32'd0,         32'd0,         32'd0,         1'b0, 1'b0, 1'b1);
      apply("t3_wrap",   32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 1'b0, 1'b1);
      apply("t4_maxp1",  32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b0, 1'b1, 1'b0);
      apply("t4_minmin", 32'h8000_0000, 32'h8000_0000, 32'd0,         1'b1, 1'b1, 1'b1);
      apply("neg_ok",    32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, 1'b0, 1'b0);

      // Reset asserted mid-stream; combinational path keeps reading 3000.
      apply("t6_pre", 32'd1000, 32'd2000, 32'd3000, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      check_comb("t6_rst_comb", 32'd3000, 1'b0, 1'b0, 1'b0);
      tick("t6_rst");
      check("t6_out_q_lit",   64'(out_q),   64'd0);
      check("t6_valid_q_lit", 64'(valid_q), 64'd0);
      check_comb("t6_after_comb", 32'd3000, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      tick("t6_release");
      check("t6_rel_out_q_lit", 64'(out_q), 64'd3000);

      // Randomised operands, half of them forced to share a sign bit.
      for (int i = 0; i < 24; i++) begin
         ra = $urandom();
         rb = $urandom();
         if (i % 2 == 0) rb[WIDTH-1] = ra[WIDTH-1];
         if (i % 5 == 0) rb = -ra;
         e = model(ra, rb, 1'b1);
         apply("rand", ra, rb, e.o, e.c, e.v, e.z);
      end

      checks++;
      assert (sb.size() == 0) else begin
         failures++;
         $error("FAIL sb_drain observed=%0d expected=0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
